// File: rtl/wb_queue_pkg.sv
// Shared register-file types for the write-back queue.
package wb_queue_pkg;

  localparam int REG_AW = 5;
  localparam int REG_DW = 32;
  localparam logic [REG_AW-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [REG_AW-1:0] dest;
    logic [REG_DW-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_queue_if.sv
// Producer handshake plus register-file write port of the write-back queue.
interface wb_queue_if
  import wb_queue_pkg::*;
#(
  parameter int AW = REG_AW,
  parameter int DW = REG_DW
);

  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_reg;
  logic [DW-1:0] in_data;
  logic          drain_en;
  logic          regWrite;
  logic [AW-1:0] writeReg;
  logic [DW-1:0] writeData;

  modport master (
    output in_valid, in_reg, in_data, drain_en,
    input  in_ready, regWrite, writeReg, writeData
  );

  modport slave (
    input  in_valid, in_reg, in_data, drain_en,
    output in_ready, regWrite, writeReg, writeData
  );

endinterface

// File: rtl/wb_queue_fwd_match.sv
// Youngest-match comparator over buffered write-back entries (built only with WBQ_FWD_EN).
module wbq_fwd_match
  import wb_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = REG_AW,
  parameter int DW    = REG_DW
) (
  input  wb_entry_t                  entries [DEPTH],
  input  logic [DEPTH-1:0]           valid,
  input  logic [$clog2(DEPTH)-1:0]   wr_ptr,
  input  logic [AW-1:0]              lookup_reg,
  output logic                       hit,
  output logic [DW-1:0]              data
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] idx;

  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    // Scan oldest to youngest so the youngest match overwrites earlier ones.
    for (int k = DEPTH; k >= 1; k--) begin
      idx = wr_ptr - PW'(k);
      if (valid[idx] && (lookup_reg != AW'(REG_ZERO)) &&
          (AW'(entries[idx].dest) == lookup_reg)) begin
        hit  = 1'b1;
        data = DW'(entries[idx].data);
      end
    end
  end

endmodule

// File: rtl/wb_queue.sv
// Write-back queue feeding the register-file write port; results to r0 are dropped.
// Define WBQ_FWD_EN to add the lookup/forwarding ports.
module wb_queue
  import wb_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = REG_AW,
  parameter int DW    = REG_DW
) (
  input  logic                     clk,
  input  logic                     rst_n,
  wb_queue_if.slave                wb,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count
`ifdef WBQ_FWD_EN
  ,
  input  logic [AW-1:0]            lookup_reg,
  output logic                     fwd_hit,
  output logic [DW-1:0]            fwd_data
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t        mem [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             push;
  logic             store;
  logic             pop;
  logic             head_vld;
  wb_entry_t        head;

  assign head     = mem[rd_ptr];
  assign head_vld = vld[rd_ptr];

  // Full blocks input even when a pop happens the same cycle.
  assign wb.in_ready = (count < CW'(DEPTH));
  assign push        = wb.in_valid && wb.in_ready;
  assign store       = push && !flush && (wb.in_reg != AW'(REG_ZERO));

  assign wb.regWrite  = (count != '0) && wb.drain_en;
  assign pop          = wb.regWrite;
  assign wb.writeReg  = head_vld ? AW'(head.dest) : '0;
  assign wb.writeData = head_vld ? DW'(head.data) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      vld    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      vld    <= '0;
    end else begin
      if (store) begin
        vld[wr_ptr] <= 1'b1;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) begin
        vld[rd_ptr] <= 1'b0;
        rd_ptr      <= rd_ptr + PW'(1);
      end
      case ({store, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (store) begin
      mem[wr_ptr] <= '{dest: REG_AW'(wb.in_reg), data: REG_DW'(wb.in_data)};
    end
  end

`ifdef WBQ_FWD_EN
  wbq_fwd_match #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_fwd (
    .entries    (mem),
    .valid      (vld),
    .wr_ptr     (wr_ptr),
    .lookup_reg (lookup_reg),
    .hit        (fwd_hit),
    .data       (fwd_data)
  );
`endif

endmodule

// File: tb/tb_wb_queue.sv
// Randomised bench for wb_queue against a queue-based model, with pinned directed cases.
module tb_wb_queue;
  import wb_queue_pkg::*;

  localparam int DEPTH = 4;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush = 1'b0;
  logic [2:0]  count;
`ifdef WBQ_FWD_EN
  logic [4:0]  lookup_reg = '0;
  logic        fwd_hit;
  logic [31:0] fwd_data;
`endif

  int checks = 0;
  int errors = 0;

  wb_queue_if #(.AW(5), .DW(32)) bus ();

  wb_queue #(.DEPTH(DEPTH), .AW(5), .DW(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wb         (bus),
    .flush      (flush),
    .count      (count)
`ifdef WBQ_FWD_EN
    ,
    .lookup_reg (lookup_reg),
    .fwd_hit    (fwd_hit),
    .fwd_data   (fwd_data)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
  } ment_t;

  ment_t q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a plain list of buffered results, oldest first.
  always @(posedge clk or negedge rst_n) begin
    bit acc;
    bit ret;
    if (!rst_n) begin
      q.delete();
    end else begin
      acc = bus.in_valid && (q.size() < DEPTH);
      ret = bus.drain_en && (q.size() != 0);
      if (flush) begin
        q.delete();
      end else begin
        if (ret) void'(q.pop_front());
        if (acc && bus.in_reg != 5'd0) q.push_back('{bus.in_reg, bus.in_data});
      end
    end
  end

  // Compare the DUT against the model every cycle, well clear of the rising edge.
  always @(negedge clk) begin
    int          n;
    logic [4:0]  er;
    logic [31:0] ed;
    #2;
    n  = q.size();
    er = (n != 0) ? q[0].r : 5'd0;
    ed = (n != 0) ? q[0].d : 32'd0;
    chk("count",     32'(count),        32'(n));
    chk("in_ready",  32'(bus.in_ready), 32'(n < DEPTH));
    chk("regWrite",  32'(bus.regWrite), 32'((n != 0) && bus.drain_en));
    chk("writeReg",  32'(bus.writeReg), 32'(er));
    chk("writeData", bus.writeData,     ed);
`ifdef WBQ_FWD_EN
    begin
      logic        h;
      logic [31:0] fd;
      h  = 1'b0;
      fd = '0;
      if (lookup_reg != 5'd0) begin
        foreach (q[i]) begin
          if (q[i].r == lookup_reg) begin
            h  = 1'b1;
            fd = q[i].d;
          end
        end
      end
      chk("fwd_hit",  32'(fwd_hit), 32'(h));
      chk("fwd_data", fwd_data,     fd);
    end
`endif
  end

  task automatic drive(input bit v, input logic [4:0] r, input logic [31:0] d,
                       input bit dr, input bit fl);
    @(negedge clk);
    bus.in_valid = v;
    bus.in_reg   = r;
    bus.in_data  = d;
    bus.drain_en = dr;
    flush        = fl;
    #3;
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_reg   = '0;
    bus.in_data  = '0;
    bus.drain_en = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #3;
    chk("rst_count",     32'(count),        32'd0);
    chk("rst_in_ready",  32'(bus.in_ready), 32'd1);
    chk("rst_regWrite",  32'(bus.regWrite), 32'd0);
    chk("rst_writeReg",  32'(bus.writeReg), 32'd0);
    chk("rst_writeData", bus.writeData,     32'd0);
    rst_n = 1'b1;

    // Single result: visible on the write port the cycle after acceptance.
    drive(1, 5'd3, 32'hDEADBEEF, 1, 0);
    chk("t1_count0", 32'(count), 32'd0);
    drive(0, 5'd0, 32'd0, 1, 0);
    chk("t1_regWrite",  32'(bus.regWrite), 32'd1);
    chk("t1_writeReg",  32'(bus.writeReg), 32'd3);
    chk("t1_writeData", bus.writeData,     32'hDEADBEEF);
    chk("t1_count1",    32'(count),        32'd1);
    drive(0, 5'd0, 32'd0, 1, 0);
    chk("t1_count_end", 32'(count),        32'd0);
    chk("t1_rw_end",    32'(bus.regWrite), 32'd0);

    // Fill with drain held off, then push against a full queue while draining.
    for (int i = 1; i <= 4; i++) drive(1, 5'(i), 32'h11 * i, 0, 0);
    drive(1, 5'd5, 32'h55, 0, 0);
    chk("t2_full_count", 32'(count),        32'd4);
    chk("t2_full_ready", 32'(bus.in_ready), 32'd0);
    chk("t2_full_rw",    32'(bus.regWrite), 32'd0);
    drive(1, 5'd5, 32'h55, 1, 0);
    chk("t2_pp_ready", 32'(bus.in_ready), 32'd0);
    chk("t2_pp_rw",    32'(bus.regWrite), 32'd1);
    chk("t2_pp_reg",   32'(bus.writeReg), 32'd1);
    chk("t2_pp_data",  bus.writeData,     32'h11);
    drive(1, 5'd7, 32'h7, 1, 0);
    chk("t2_c3",       32'(count),        32'd3);
    chk("t2_ready3",   32'(bus.in_ready), 32'd1);
    chk("t2_reg2",     32'(bus.writeReg), 32'd2);
    drive(0, 5'd0, 32'd0, 1, 0);
    chk("t2_reg3",     32'(bus.writeReg), 32'd3);
    drive(0, 5'd0, 32'd0, 1, 0);
    chk("t2_reg4",     32'(bus.writeReg), 32'd4);
    drive(0, 5'd0, 32'd0, 1, 0);
    chk("t2_reg7",     32'(bus.writeReg), 32'd7);
    chk("t2_data7",    bus.writeData,     32'h7);
    drive(0, 5'd0, 32'd0, 1, 0);
    chk("t2_empty",    32'(count),        32'd0);

    // Results targeting r0 complete the handshake but are never stored.
    drive(1, 5'd0, 32'h1234, 1, 0);
    chk("t3_ready", 32'(bus.in_ready), 32'd1);
    drive(0, 5'd0, 32'd0, 1, 0);
    chk("t3_count", 32'(count),        32'd0);
    chk("t3_rw",    32'(bus.regWrite), 32'd0);

`ifdef WBQ_FWD_EN
    lookup_reg = 5'd5;
    drive(1, 5'd5, 32'hA, 0, 0);
    chk("t4_enq_hidden", 32'(fwd_hit), 32'd0);
    drive(1, 5'd5, 32'hB, 0, 0);
    chk("t4_hit_a",  32'(fwd_hit), 32'd1);
    chk("t4_data_a", fwd_data,     32'hA);
    drive(0, 5'd0, 32'd0, 0, 0);
    chk("t4_hit_b",  32'(fwd_hit), 32'd1);
    chk("t4_data_b", fwd_data,     32'hB);
    lookup_reg = 5'd6;
    #1;
    chk("t4_miss",   32'(fwd_hit), 32'd0);
    chk("t4_miss_d", fwd_data,     32'd0);
    lookup_reg = 5'd0;
    #1;
    chk("t4_r0_miss", 32'(fwd_hit), 32'd0);
    lookup_reg = 5'd5;
    drive(0, 5'd0, 32'd0, 1, 0);
    drive(0, 5'd0, 32'd0, 1, 0);
    chk("t4_retiring_visible", 32'(fwd_hit), 32'd1);
    chk("t4_retiring_data",    fwd_data,     32'hB);
    drive(0, 5'd0, 32'd0, 0, 1);
    drive(0, 5'd0, 32'd0, 0, 0);
    chk("t4_flushed", 32'(count), 32'd0);
`endif

    // Flush with three entries, then asynchronous reset mid-drain.
    drive(1, 5'd1, 32'h101, 0, 0);
    drive(1, 5'd2, 32'h102, 0, 0);
    drive(1, 5'd3, 32'h103, 0, 0);
    drive(1, 5'd9, 32'h9, 1, 1);
    chk("t5_fl_count", 32'(count),        32'd3);
    chk("t5_fl_rw",    32'(bus.regWrite), 32'd1);
    chk("t5_fl_reg",   32'(bus.writeReg), 32'd1);
    drive(0, 5'd0, 32'd0, 1, 0);
    chk("t5_post_count", 32'(count),        32'd0);
    chk("t5_post_rw",    32'(bus.regWrite), 32'd0);
    drive(1, 5'd4, 32'h44, 0, 0);
    drive(1, 5'd5, 32'h55, 0, 0);
    drive(0, 5'd0, 32'd0, 1, 0);
    chk("t5_pre_rst_rw",  32'(bus.regWrite), 32'd1);
    chk("t5_pre_rst_reg", 32'(bus.writeReg), 32'd4);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_count", 32'(count),        32'd0);
    chk("t5_rst_rw",    32'(bus.regWrite), 32'd0);
    chk("t5_rst_ready", 32'(bus.in_ready), 32'd1);
    drive(0, 5'd0, 32'd0, 1, 0);
    chk("t5_rst_hold_rw", 32'(bus.regWrite), 32'd0);
    rst_n = 1'b1;
    drive(0, 5'd0, 32'd0, 1, 0);
    chk("t5_after_count", 32'(count),        32'd0);
    chk("t5_after_rw",    32'(bus.regWrite), 32'd0);

    // Random traffic; small register range so duplicates and forwarding hits are common.
    for (int n = 0; n < 3000; n++) begin
`ifdef WBQ_FWD_EN
      lookup_reg = 5'($urandom_range(0, 7));
`endif
      drive(($urandom_range(0, 9) < 7),
            5'($urandom_range(0, 7)),
            $urandom,
            ($urandom_range(0, 9) < 6),
            ($urandom_range(0, 99) < 3));
    end

    drive(0, 5'd0, 32'd0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_queue.md
Name: wb_queue

Overview:
- Write-side feeder for the 32x32 register file: buffers completed results (destination register, data) from execute/memory and retires them into the register-file write port, at most one per cycle.
- Decouples producers from write-port availability via a valid/ready handshake.
- Optionally supplies forwarding data for results still buffered, so decode never reads a stale register.

Parameters:
- DEPTH, 4, number of queue entries; power of two, minimum 2.
- AW, 5, register address width.
- DW, 32, data width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  producer offers a result.
- in_ready  output  1  queue can accept; equals (count < DEPTH).
- in_reg  input  AW  destination register.
- in_data  input  DW  result value.
- drain_en  input  1  register-file write port available this cycle.
- flush  input  1  synchronous discard of all buffered entries.
- regWrite  output  1  write strobe to the register file.
- writeReg  output  AW  register-file write address.
- writeData  output  DW  register-file write data.
- count  output  $clog2(DEPTH)+1  current occupancy.
- lookup_reg  input  AW  decode-stage source register (WBQ_FWD_EN only).
- fwd_hit  output  1  lookup_reg matches a buffered entry (WBQ_FWD_EN only).
- fwd_data  output  DW  data of the youngest matching entry (WBQ_FWD_EN only).

Behaviour:
- Circular FIFO with wr_ptr, rd_ptr and count.
- Reset (rst_n low, asynchronous): pointers and count = 0, all entry valid bits = 0. Outputs: regWrite = 0, writeReg = 0, writeData = 0, in_ready = 1, fwd_hit = 0, fwd_data = 0.
- Enqueue: occurs on an edge where in_valid && in_ready.
  - in_reg == 0 is accepted but discarded: handshake completes, nothing is stored, count is unchanged. Register 0 is never written.
- Retire (combinational outputs from the head entry):
  - regWrite = (count != 0) && drain_en.
  - writeReg and writeData = head entry when count != 0; otherwise 0.
  - On an edge with regWrite = 1, the head is popped.
- Latency: a result accepted at edge N drives regWrite during cycle N+1 and is written to the register file at edge N+1 (given drain_en = 1). No same-cycle bypass from input to write port.
- Simultaneous push and pop: count unchanged, both pointers advance. When full, in_ready = 0 even if a pop occurs that cycle (no full-pass-through).
- Order: strictly FIFO. Two entries to the same register retire in order, so the last value wins.
- Pointer wrap at DEPTH is modulo; count distinguishes full from empty.
- flush: on the next edge, count and pointers = 0. Any same-cycle enqueue is dropped and any same-cycle retire still occurs on the write port but is not re-queued. flush has priority over push and pop.
- drain_en = 0: queue holds; regWrite = 0; producers back-pressure once full.

Optional Feature:
- WBQ_FWD_EN defined:
  - lookup ports exist; combinational compare of lookup_reg against all valid entries.
  - fwd_hit = 1 and fwd_data = youngest match (closest to wr_ptr-1).
  - lookup_reg == 0 never hits.
  - The entry being enqueued this cycle is not visible. The entry retiring this cycle is still visible.
- WBQ_FWD_EN undefined: lookup ports and compare logic are absent; decode must stall on a nonzero count.

Decomposition:
- Shared package: REG_AW = 5, REG_DW = 32, REG_ZERO = 0, and a wb_entry_t struct {reg, data}.
- One natural sub-module, wbq_fwd_match: a priority-by-age comparator over entries, instantiated only under WBQ_FWD_EN.

Test Plan:
- Reset, then push (r3, 0xDEADBEEF) with drain_en = 1 -> regWrite = 1, writeReg = 3, writeData = 0xDEADBEEF the next cycle; count returns to 0 after the following edge.
- drain_en = 0, push 4 entries r1..r4 -> count = 4, in_ready = 0, 5th push stalls. Raise drain_en -> writes r1..r4 in order, one per cycle.
- Push (r0, 0x1234) -> in_ready stays 1, count stays 0, regWrite never asserts.
- Full queue with push and drain in the same cycle -> push refused, pop occurs, count = 3; next cycle push (r7, 0x7) accepted, retires last.
- WBQ_FWD_EN: queue holds (r5, 0xA) then (r5, 0xB), drain_en = 0, lookup_reg = 5 -> fwd_hit = 1, fwd_data = 0xB. lookup_reg = 6 -> fwd_hit = 0.
- With 3 entries, assert flush, then rst_n low mid-drain -> count = 0, regWrite = 0 immediately on reset and on the edge after flush; no further writes issued.
